// File: rtl/timer_mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_mm_pkg
//  Description : Shared types and constants for the timer Avalon-MM host.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_mm_pkg;

    // Command opcodes accepted on the cmd_* interface
    typedef enum logic [1:0] {
        OP_WRITE_CTRL   = 2'd0,
        OP_READ_CTRL    = 2'd1,
        OP_READ_COUNTER = 2'd2,
        OP_MEASURE      = 2'd3
    } op_e;

    // Top-level sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_DLY  = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    // MEASURE phase: START write sets RUN, STOP write clears it
    localparam logic PH_START = 1'b0;
    localparam logic PH_STOP  = 1'b1;

    // Timer slave register map
    localparam logic CTRL_ADDR    = 1'b0;
    localparam logic COUNTER_ADDR = 1'b1;
    localparam int   CTRL_RUN_BIT = 0;

endpackage : timer_mm_pkg
`default_nettype wire

// File: rtl/timer_mm_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : timer_mm_xfer
//  Description : Single Avalon-MM read/write transfer engine. Holds the strobe
//                with stable address/data while waitrequest is high and aborts
//                after TIMEOUT_CYCLES consecutive stalled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_mm_xfer #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              start_write,
    input  logic              start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              active;

    assign active        = read_q | write_q;
    assign done          = active & ~avm_waitrequest;
    assign err           = active & avm_waitrequest & (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rdata         = avm_readdata;
    assign avm_address   = address_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = writedata_q;

    // Strobe lifetime: end on completion/timeout, count stalls, a new start overrides
    always_comb begin
        read_d      = read_q;
        write_d     = write_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        tmo_d       = tmo_q;
        if (done || err) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            tmo_d   = '0;
        end else if (active) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (start) begin
            read_d    = ~start_write;
            write_d   = start_write;
            address_d = start_addr;
            tmo_d     = '0;
            if (start_write) begin
                writedata_d = start_wdata;
            end
        end
    end

    // Bus-facing registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= 1'b0;
            writedata_q <= '0;
            tmo_q       <= '0;
        end else begin
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule : timer_mm_xfer
`default_nettype wire

// File: rtl/timer_mm_master.sv
`default_nettype none
// ============================================================================
//  Module      : timer_mm_master
//  Description : Avalon-MM host for the timer slave. Executes single CTRL /
//                COUNTER accesses and the self-timed MEASURE sequence from a
//                valid/ready command interface.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_mm_master
    import timer_mm_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [DATA_W-1:0] RUN_WORD = DATA_W'(1) << CTRL_RUN_BIT;

    logic [2:0]        state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic              phase_q, phase_d;
    logic [DATA_W-1:0] dly_q, dly_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              x_start, x_write, x_addr;
    logic [DATA_W-1:0] x_wdata, x_rdata;
    logic              x_done, x_err;

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    timer_mm_xfer #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .clk             (clk),
        .reset           (reset),
        .start           (x_start),
        .start_write     (x_write),
        .start_addr      (x_addr),
        .start_wdata     (x_wdata),
        .done            (x_done),
        .err             (x_err),
        .rdata           (x_rdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // Command sequencer: decides the next transfer and when to respond
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        n_d        = n_q;
        phase_d    = phase_q;
        dly_d      = dly_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        x_start    = 1'b0;
        x_write    = 1'b0;
        x_addr     = CTRL_ADDR;
        x_wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    n_d     = cmd_wdata;
                    phase_d = PH_START;
                    x_start = 1'b1;
                    case (op_e'(cmd_op))
                        OP_WRITE_CTRL: begin
                            x_write = 1'b1;
                            x_wdata = cmd_wdata;
                            state_d = ST_WR;
                        end
                        OP_READ_CTRL: begin
                            state_d = ST_RD;
                        end
                        OP_READ_COUNTER: begin
                            x_addr  = COUNTER_ADDR;
                            state_d = ST_RD;
                        end
                        OP_MEASURE: begin
                            x_write = 1'b1;
                            x_wdata = RUN_WORD;
                            state_d = ST_WR;
                        end
                    endcase
                end
            end
            ST_WR: begin
                if (x_err) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = ST_RSP;
                end else if (x_done) begin
                    if (op_q == OP_MEASURE && phase_q == PH_START) begin
                        if (n_q != '0) begin
                            dly_d   = n_q;
                            state_d = ST_DLY;
                        end else begin
                            x_start = 1'b1;
                            x_addr  = COUNTER_ADDR;
                            state_d = ST_RD;
                        end
                    end else begin
                        // STOP write keeps the count captured by the preceding read
                        if (op_q == OP_WRITE_CTRL) begin
                            rsp_data_d = '0;
                        end
                        state_d = ST_RSP;
                    end
                end
            end
            ST_RD: begin
                if (x_err) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = ST_RSP;
                end else if (x_done) begin
                    rsp_data_d = x_rdata;
                    if (op_q == OP_MEASURE) begin
                        x_start = 1'b1;
                        x_write = 1'b1;
                        x_wdata = '0;
                        phase_d = PH_STOP;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RSP;
                    end
                end
            end
            ST_DLY: begin
                if (dly_q == DATA_W'(1)) begin
                    x_start = 1'b1;
                    x_addr  = COUNTER_ADDR;
                    state_d = ST_RD;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_err_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE_CTRL;
            n_q        <= '0;
            phase_q    <= PH_START;
            dly_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            n_q        <= n_d;
            phase_q    <= phase_d;
            dly_q      <= dly_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule : timer_mm_master
`default_nettype wire

// File: tb/tb_timer_mm_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_mm_master
//  Description : Self-checking bench for timer_mm_master against a behavioural
//                timer slave with programmable waitrequest stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_mm_master;
    import timer_mm_pkg::*;

    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    timer_mm_master #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    // ---------------- timer slave model ----------------
    logic [31:0] t_ctrl    = 32'd0;
    logic [31:0] t_count   = 32'd0;
    int          start_cyc = 0;
    int          cyc       = 0;
    logic        stall_stuck = 1'b0;
    int          stall_n     = 0;
    int          run_len     = 0;

    always_comb begin
        avm_waitrequest = stall_stuck || ((avm_read || avm_write) && (run_len < stall_n));
        if (avm_waitrequest)
            avm_readdata = 32'hDEADBEEF;
        else if (avm_address == COUNTER_ADDR)
            avm_readdata = t_count;
        else
            avm_readdata = t_ctrl;
    end

    // Counter runs while RUN is set; a CTRL write with RUN restarts it from 0
    always @(posedge clk) begin
        if (t_ctrl[CTRL_RUN_BIT]) t_count <= t_count + 32'd1;
        if (avm_write && !avm_waitrequest && avm_address == CTRL_ADDR) begin
            t_ctrl <= avm_writedata;
            if (avm_writedata[CTRL_RUN_BIT]) begin
                t_count   <= 32'd0;
                start_cyc <= cyc;
            end
        end
    end

    // ---------------- bus monitor / transfer log ----------------
    logic        lg_wr   [64];
    logic        lg_addr [64];
    logic [31:0] lg_data [64];
    int          lg_len  [64];
    int          lg_cyc  [64];
    int          lg_n      = 0;
    int          abort_len = 0;
    logic        both_seen = 1'b0;
    logic        unstable  = 1'b0;
    logic        prev_addr = 1'b0;
    logic        prev_rd   = 1'b0;
    logic [31:0] prev_wd   = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_read && avm_write) both_seen <= 1'b1;
        if (avm_read || avm_write) begin
            if (run_len > 0 && (avm_address != prev_addr || avm_read != prev_rd || avm_writedata != prev_wd))
                unstable <= 1'b1;
            prev_addr <= avm_address;
            prev_rd   <= avm_read;
            prev_wd   <= avm_writedata;
            if (!avm_waitrequest) begin
                if (lg_n < 64) begin
                    lg_wr[lg_n]   <= avm_write;
                    lg_addr[lg_n] <= avm_address;
                    lg_data[lg_n] <= avm_write ? avm_writedata : avm_readdata;
                    lg_len[lg_n]  <= run_len + 1;
                    lg_cyc[lg_n]  <= cyc;
                    lg_n          <= lg_n + 1;
                end
                run_len <= 0;
            end else begin
                run_len <= run_len + 1;
            end
        end else begin
            if (run_len > 0) abort_len <= run_len;
            run_len <= 0;
        end
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   rsp_first = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        rsp_t r;
        r.data = d;
        r.err  = e;
        exp_q.push_back(r);
    endtask

    task automatic send(input op_e op, input logic [31:0] wd, output int acc);
        int b;
        b         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        while (!cmd_ready && b < 50) begin
            step();
            b++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        step();
        acc       = cyc - 1;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag);
        int   b;
        rsp_t e;
        b = 0;
        while (!rsp_valid && b < 400) begin
            step();
            b++;
        end
        rsp_first = cyc;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.data = 32'hFFFFFFFF;
            e.err  = 1'b1;
        end
        check({tag, "_data"}, rsp_data, e.data);
        check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        step();
        check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int base;
        int stray;
        int exp_cnt;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_addr", 32'(avm_address), 32'd0);
        check("rst_avm_wdata", avm_writedata, 32'd0);
        rsp_ready = 1'b1;

        // WRITE_CTRL 0x1
        base = lg_n;
        push(32'd0, 1'b0);
        send(OP_WRITE_CTRL, 32'h1, acc);
        expect_rsp("wr_ctrl");
        check("wr_ctrl_nxfer", 32'(lg_n - base), 32'd1);
        check("wr_ctrl_is_wr", 32'(lg_wr[base]), 32'd1);
        check("wr_ctrl_addr", 32'(lg_addr[base]), 32'd0);
        check("wr_ctrl_wdata", lg_data[base], 32'h1);
        check("wr_ctrl_len", 32'(lg_len[base]), 32'd1);
        check("wr_ctrl_cycle", 32'(lg_cyc[base]), 32'(acc + 1));

        // READ_CTRL
        base = lg_n;
        push(32'h1, 1'b0);
        send(OP_READ_CTRL, 32'h0, acc);
        expect_rsp("rd_ctrl");
        check("rd_ctrl_is_rd", 32'(lg_wr[base]), 32'd0);
        check("rd_ctrl_addr", 32'(lg_addr[base]), 32'd0);

        // READ_COUNTER after 5 idle cycles; read completes one edge after acceptance
        repeat (5) step();
        base = lg_n;
        send(OP_READ_COUNTER, 32'h0, acc);
        exp_cnt = acc - start_cyc;
        push(32'(exp_cnt), 1'b0);
        expect_rsp("rd_cnt");
        check("rd_cnt_addr", 32'(lg_addr[base]), 32'd1);
        check("rd_cnt_nonzero", 32'(lg_data[base] != 32'd0), 32'd1);

        // MEASURE N=10
        base = lg_n;
        push(32'd10, 1'b0);
        send(OP_MEASURE, 32'd10, acc);
        expect_rsp("meas10");
        check("meas10_nxfer", 32'(lg_n - base), 32'd3);
        check("meas10_start", {lg_wr[base], lg_addr[base], lg_data[base][29:0]}, {1'b1, 1'b0, 30'd1});
        check("meas10_read", {lg_wr[base+1], lg_addr[base+1], lg_data[base+1][29:0]}, {1'b0, 1'b1, 30'd10});
        check("meas10_stop", {lg_wr[base+2], lg_addr[base+2], lg_data[base+2][29:0]}, {1'b1, 1'b0, 30'd0});
        check("meas10_t_start", 32'(lg_cyc[base]), 32'(acc + 1));
        check("meas10_t_read", 32'(lg_cyc[base+1] - lg_cyc[base]), 32'd11);
        check("meas10_t_stop", 32'(lg_cyc[base+2] - lg_cyc[base+1]), 32'd1);
        check("meas10_t_rsp", 32'(rsp_first), 32'(lg_cyc[base+2] + 1));

        // MEASURE N=0
        base = lg_n;
        push(32'd0, 1'b0);
        send(OP_MEASURE, 32'd0, acc);
        expect_rsp("meas0");
        check("meas0_nxfer", 32'(lg_n - base), 32'd3);
        check("meas0_t_read", 32'(lg_cyc[base+1] - lg_cyc[base]), 32'd1);

        // Read held for 3 waitrequest cycles
        push(32'd0, 1'b0);
        send(OP_WRITE_CTRL, 32'h6, acc);
        expect_rsp("wr_ctrl6");
        stall_n = 3;
        base    = lg_n;
        push(32'h6, 1'b0);
        send(OP_READ_CTRL, 32'h0, acc);
        expect_rsp("stall_rd");
        stall_n = 0;
        check("stall_len", 32'(lg_len[base]), 32'd4);
        check("stall_stable", 32'(unstable), 32'd0);

        // Stuck waitrequest -> timeout after TMO cycles
        stall_stuck = 1'b1;
        base        = lg_n;
        push(32'd0, 1'b1);
        send(OP_READ_COUNTER, 32'h0, acc);
        expect_rsp("tmo");
        stall_stuck = 1'b0;
        check("tmo_strobe_len", 32'(abort_len), 32'(TMO));
        check("tmo_no_xfer", 32'(lg_n - base), 32'd0);
        push(32'h6, 1'b0);
        send(OP_READ_CTRL, 32'h0, acc);
        expect_rsp("after_tmo");

        // Reset while a read is stalled drops the strobe at once
        stall_stuck = 1'b1;
        send(OP_READ_CTRL, 32'h0, acc);
        repeat (3) step();
        check("rst_stall_pre", 32'(avm_read), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("rst_stall_read", 32'(avm_read), 32'd0);
        stall_stuck = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Reset during the delay of MEASURE N=100
        send(OP_MEASURE, 32'd100, acc);
        repeat (20) step();
        #3;
        reset = 1'b0;
        #1;
        check("rst_dly_rd", 32'(avm_read), 32'd0);
        check("rst_dly_wr", 32'(avm_write), 32'd0);
        check("rst_dly_rsp", 32'(rsp_valid), 32'd0);
        step();
        step();
        reset = 1'b1;
        base  = lg_n;
        step();
        check("rst_rel_ready", 32'(cmd_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 150; i++) begin
            if (rsp_valid || avm_read || avm_write) stray++;
            step();
        end
        check("rst_no_stray", 32'(stray), 32'd0);
        check("rst_no_xfer", 32'(lg_n - base), 32'd0);
        push(32'h1, 1'b0);
        send(OP_READ_CTRL, 32'h0, acc);
        expect_rsp("post_rst");

        check("never_both", 32'(both_seen), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_timer_mm_master
`default_nettype wire

// File: doc/timer_mm_master.md
Name: timer_mm_master

Overview:
- Avalon-MM host that drives the custom timer's two-register slave port (CTRL at address 0, COUNTER at address 1) from a simple valid/ready command interface.
- Performs single register writes and reads, plus a self-timed MEASURE sequence: start the timer, wait N cycles, sample COUNTER, stop the timer.
- Sits between a control source (test sequencer or Nios-side bridge) and the timer slave; it is the initiator end of the timer's memory-mapped interface.

Parameters:
- DATA_W, 32, bus and command data width.
- TIMEOUT_CYCLES, 256, number of consecutive waitrequest-high cycles after which a transfer is aborted; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=WRITE_CTRL, 1=READ_CTRL, 2=READ_COUNTER, 3=MEASURE.
- cmd_wdata  in  DATA_W  CTRL value for WRITE_CTRL; delay N for MEASURE; ignored otherwise.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  response accepted.
- rsp_data  out  DATA_W  read data: CTRL, COUNTER or measured count; 0 for WRITE_CTRL and on error.
- rsp_err  out  1  transfer timed out.
- avm_address  out  1  0=CTRL, 1=COUNTER.
- avm_read  out  1  read strobe.
- avm_write  out  1  write strobe.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  slave read data; zero-latency, valid in the cycle avm_read is high and avm_waitrequest is low.
- avm_waitrequest  in  1  slave stall; tie low for slaves without stall.

Behaviour:
- Reset (async, active-low): state=IDLE; cmd_ready=1 after release; rsp_valid=0, rsp_err=0, rsp_data=0; avm_read=0, avm_write=0, avm_address=0, avm_writedata=0; delay and timeout counters=0. Reset mid-transfer drops strobes immediately; no response is produced.
- States: IDLE, WR, RD, DLY, RSP.
- IDLE: on cmd_valid&&cmd_ready, latch op and wdata.
  - WRITE_CTRL -> WR(addr 0, data wdata).
  - READ_CTRL -> RD(addr 0).
  - READ_COUNTER -> RD(addr 1).
  - MEASURE -> WR(addr 0, data 1), phase=START.
- WR: avm_write=1 with stable address/data until the first cycle with waitrequest=0; the transfer completes at that clock edge.
  - Next state: WRITE_CTRL -> RSP.
  - MEASURE START -> DLY if N>0, else RD(addr 1).
  - MEASURE STOP -> RSP.
- RD: avm_read=1 held likewise; capture avm_readdata in the completion cycle.
  - Next state: single read -> RSP.
  - MEASURE -> WR(addr 0, data 0), phase=STOP, captured count retained.
- DLY: exactly N cycles (down-counter loaded with N, exits when it reaches 1), then RD(addr 1). No bus strobes.
- Timeout: counter increments each WR/RD cycle with waitrequest=1 and clears on state entry. On reaching TIMEOUT_CYCLES: deassert strobe, go to RSP with rsp_err=1, rsp_data=0. A MEASURE that times out does not issue the STOP write.
- RSP: rsp_valid=1 with stable data/err until the rsp_ready cycle, then IDLE. rsp_valid and rsp_err clear on that edge. cmd_ready=0 throughout.
- avm_read and avm_write are never both high. Strobes are registered outputs with no combinational path from cmd_* to avm_*.
- MEASURE latency with zero-wait slave: WR 1 + DLY N + RD 1 + WR 1 cycles, then rsp_valid. Result against the timer equals N (counter increments from the cycle after CTRL write). N=0 gives 0. The N counter is DATA_W bits wide, so N=0xFFFFFFFF is legal and has no wrap issues.
- Back-to-back: a new command is accepted in the first IDLE cycle after the rsp handshake. Minimum 1 idle cycle between responses.

Decomposition:
- Package timer_mm_pkg:
  - op enum (WRITE_CTRL, READ_CTRL, READ_COUNTER, MEASURE).
  - state enum.
  - CTRL_ADDR=1'b0, COUNTER_ADDR=1'b1.
  - CTRL_RUN_BIT=0.
- Sub-module timer_mm_xfer: single read/write transfer engine with waitrequest hold and timeout. Outputs done, err, rdata. The top FSM sequences it.

Test Plan:
- WRITE_CTRL 0x1, zero-wait slave -> one cycle avm_write=1, addr 0, data 0x1; rsp_valid with rsp_data=0, rsp_err=0.
- READ_CTRL after that write -> avm_read addr 0; rsp_data=0x1. READ_COUNTER after 5 idle cycles -> value consistent with the timer model, nonzero.
- MEASURE N=10 against the timer model -> sequence write(0,1), 10 idle cycles, read(1), write(0,0); rsp_data=10. MEASURE N=0 -> rsp_data=0.
- Slave holds waitrequest 3 cycles on a read -> strobe and address stable for 4 cycles; data captured in 4th; rsp_err=0.
- TIMEOUT_CYCLES=8, waitrequest stuck high -> strobe drops after 8 cycles; rsp_err=1, rsp_data=0; next command accepted normally.
- Assert reset during DLY of MEASURE N=100 -> all strobes 0 and rsp_valid=0 immediately; cmd_ready=1 after release; no stray response.
